// File: rtl/division_4bits_seq_pkg.sv
// rtl/division_4bits_seq_pkg.sv - shared state encoding, default width and sign helper for the divider
package division_4bits_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // 2-bit encoding; 2'b11 is unused and recovers to S_IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A zero magnitude is always reported as positive
  function automatic logic zero_gated_sign(input logic sign, input logic nonzero);
    return sign & nonzero;
  endfunction

endpackage

// File: rtl/division_step.sv
// rtl/division_step.sv - one combinational restoring shift/subtract iteration
module division_step
  import division_4bits_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;

  // Shift {P,Q} left, trial-subtract D, keep the difference only when it is non-negative
  always_comb begin
    shifted = {p, q} << 1;
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, d};
    if (!trial[WIDTH]) begin
      p_next = trial;
      q_next = shifted[WIDTH-1:0] | WIDTH'(1);
    end else begin
      p_next = shifted[2*WIDTH:WIDTH];
      q_next = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/division_4bits_seq.sv
// rtl/division_4bits_seq.sv - sequential restoring divider with sign-magnitude results and start/busy/done handshake
module division_4bits_seq
  import division_4bits_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_mag,
  input  logic             dividend_sign,
  input  logic [WIDTH-1:0] divisor_mag,
  input  logic             divisor_sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient_mag,
  output logic             quotient_sign,
  output logic [WIDTH-1:0] remainder_mag,
  output logic             remainder_sign,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             dividend_sign_r;
  logic             divisor_sign_r;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  division_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .q      (q),
    .d      (d),
    .p_next (p_next),
    .q_next (q_next)
  );

  // Control FSM, iteration counter, working registers and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      count           <= '0;
      p               <= '0;
      q               <= '0;
      d               <= '0;
      dividend_sign_r <= 1'b0;
      divisor_sign_r  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      quotient_mag    <= '0;
      quotient_sign   <= 1'b0;
      remainder_mag   <= '0;
      remainder_sign  <= 1'b0;
      div_by_zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            dividend_sign_r <= dividend_sign;
            divisor_sign_r  <= divisor_sign;
            d               <= divisor_mag;
            q               <= dividend_mag;
            p               <= '0;
            count           <= '0;
            busy            <= 1'b1;
            div_by_zero     <= 1'b0;
            if (divisor_mag == '0) begin
              // Zero divisor skips the iterations and reports immediately
              state          <= S_DONE;
              done           <= 1'b1;
              div_by_zero    <= 1'b1;
              quotient_mag   <= '0;
              quotient_sign  <= 1'b0;
              remainder_mag  <= dividend_mag;
              remainder_sign <= zero_gated_sign(dividend_sign, |dividend_mag);
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          p     <= p_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state          <= S_DONE;
            done           <= 1'b1;
            quotient_mag   <= q_next;
            quotient_sign  <= zero_gated_sign(dividend_sign_r ^ divisor_sign_r, |q_next);
            remainder_mag  <= p_next[WIDTH-1:0];
            remainder_sign <= zero_gated_sign(dividend_sign_r, |p_next[WIDTH-1:0]);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division_4bits_seq.sv
// tb/tb_division_4bits_seq.sv - directed self-checking bench for the sequential divider
module tb_division_4bits_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend_mag;
  logic       dividend_sign;
  logic [3:0] divisor_mag;
  logic       divisor_sign;
  logic       busy;
  logic       done;
  logic [3:0] quotient_mag;
  logic       quotient_sign;
  logic [3:0] remainder_mag;
  logic       remainder_sign;
  logic       div_by_zero;

  int checks;
  int failures;

  int         done_cnt;
  int         done_at [4];
  logic [3:0] qm [4];
  logic       qs [4];
  logic [3:0] rm [4];
  logic       rs [4];
  logic       dz [4];
  logic       busy_hist [32];
  logic       done_hist [32];
  logic       dbz_hist [32];

  division_4bits_seq #(.WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dividend_mag   (dividend_mag),
    .dividend_sign  (dividend_sign),
    .divisor_mag    (divisor_mag),
    .divisor_sign   (divisor_sign),
    .busy           (busy),
    .done           (done),
    .quotient_mag   (quotient_mag),
    .quotient_sign  (quotient_sign),
    .remainder_mag  (remainder_mag),
    .remainder_sign (remainder_sign),
    .div_by_zero    (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample n cycles (index 0 = cycle after the accepting edge), recording done pulses
  task automatic observe(input int n, input int pulse_at, input bit hold);
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      busy_hist[i] = busy;
      done_hist[i] = done;
      dbz_hist[i]  = div_by_zero;
      if (done && done_cnt < 4) begin
        done_at[done_cnt] = i;
        qm[done_cnt] = quotient_mag;
        qs[done_cnt] = quotient_sign;
        rm[done_cnt] = remainder_mag;
        rs[done_cnt] = remainder_sign;
        dz[done_cnt] = div_by_zero;
      end
      if (done) done_cnt++;
      start = hold || (i == pulse_at);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic as, input logic [3:0] b, input logic bs,
                        input int pulse_at);
    dividend_mag  = a;
    dividend_sign = as;
    divisor_mag   = b;
    divisor_sign  = bs;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    observe(10, pulse_at, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend_mag = '0;
    dividend_sign = 1'b0;
    divisor_mag = '0;
    divisor_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_q", quotient_mag, 0);
    check_eq("rst_r", remainder_mag, 0);
    check_eq("rst_dbz", div_by_zero, 0);

    // 7+ / 2+
    run_op(4'd7, 1'b0, 4'd2, 1'b0, -1);
    check_eq("t1_busy0", busy_hist[0], 1);
    check_eq("t1_ndone", done_cnt, 1);
    check_eq("t1_lat", done_at[0], 4);
    check_eq("t1_q", qm[0], 3);
    check_eq("t1_qs", qs[0], 0);
    check_eq("t1_r", rm[0], 1);
    check_eq("t1_rs", rs[0], 0);
    check_eq("t1_dbz", dz[0], 0);
    check_eq("t1_busy_after", busy_hist[5], 0);
    check_eq("t1_done_after", done_hist[5], 0);
    check_eq("t1_hold_q", quotient_mag, 3);

    // 9- / 3+
    run_op(4'd9, 1'b1, 4'd3, 1'b0, -1);
    check_eq("t2_q", qm[0], 3);
    check_eq("t2_qs", qs[0], 1);
    check_eq("t2_r", rm[0], 0);
    check_eq("t2_rs", rs[0], 0);

    // 5- / 0
    run_op(4'd5, 1'b1, 4'd0, 1'b0, -1);
    check_eq("t3_ndone", done_cnt, 1);
    check_eq("t3_lat", done_at[0], 0);
    check_eq("t3_dbz", dz[0], 1);
    check_eq("t3_q", qm[0], 0);
    check_eq("t3_qs", qs[0], 0);
    check_eq("t3_r", rm[0], 5);
    check_eq("t3_rs", rs[0], 1);
    check_eq("t3_done_after", done_hist[1], 0);

    // 15 / 4 with a second start during RUN
    run_op(4'd15, 1'b0, 4'd4, 1'b0, 1);
    check_eq("t4_dbz_clr", dbz_hist[0], 0);
    check_eq("t4_ndone", done_cnt, 1);
    check_eq("t4_lat", done_at[0], 4);
    check_eq("t4_q", qm[0], 3);
    check_eq("t4_r", rm[0], 3);

    // 15 / 1 aborted by reset two cycles after start
    dividend_mag = 4'd15;
    dividend_sign = 1'b1;
    divisor_mag = 4'd1;
    divisor_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_done", done, 0);
    check_eq("t5_q", quotient_mag, 0);
    check_eq("t5_r", remainder_mag, 0);
    check_eq("t5_qs", quotient_sign, 0);
    check_eq("t5_rs", remainder_sign, 0);
    observe(8, -1, 1'b0);
    check_eq("t5_no_done", done_cnt, 0);
    run_op(4'd6, 1'b0, 4'd4, 1'b0, -1);
    check_eq("t5_lat", done_at[0], 4);
    check_eq("t5_q2", qm[0], 1);
    check_eq("t5_r2", rm[0], 2);

    // 0/7 then 3/5 back-to-back with start held high
    dividend_mag = 4'd0;
    dividend_sign = 1'b0;
    divisor_mag = 4'd7;
    divisor_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    dividend_mag = 4'd3;
    divisor_mag = 4'd5;
    observe(12, -1, 1'b1);
    start = 1'b0;
    check_eq("t6_ndone", done_cnt, 2);
    check_eq("t6_lat1", done_at[0], 4);
    check_eq("t6_lat2", done_at[1], 10);
    check_eq("t6_q1", qm[0], 0);
    check_eq("t6_r1", rm[0], 0);
    check_eq("t6_q2", qm[1], 0);
    check_eq("t6_r2", rm[1], 3);
    check_eq("t6_rs2", rs[1], 0);
    repeat (8) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
